aec_token_sequencer: RTL

// - Front-end controller for the AEC expression evaluator. Captures one ASCII expression frame
//   (first char on ready, then one char per cycle until '='). Classifies each char into a token
//   and buffers it in a FIFO. Issues tokens to the evaluation core over a valid/ack handshake.
// - The ASCII source cannot be stalled, so capture runs at line rate and the FIFO decouples it

---
 rtl/aec_token_sequencer.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aec_token_sequencer.sv
// aec_token_sequencer -- front end of the AEC expression evaluator.
// Purpose : captures one ASCII expression frame at line rate (first char
//           with ready, then one char per cycle up to and including '='),
//           classifies each char into a token, buffers the tokens in a FIFO
//           and issues them to the evaluation core over a valid/ack handshake.
// Latency : a char accepted in cycle N reaches the FIFO head no earlier than
//           N+1. The tok_* outputs come straight from the head entry.
// Backpressure: the ASCII source cannot be stalled. If the FIFO is full and
//           nothing pops, the incoming token is dropped and ovf is set. A
//           dropped '=' is re-created once a slot frees, so every frame still
//           ends with exactly one end token.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ready, ascii_in     frame start strobe and the ASCII char stream
//   tok_valid           a token is present on tok_kind/tok_value (FIFO not empty)
//   tok_kind[1:0]       0=operand 1=operator 2=paren 3=end
//   tok_value[3:0]      operand 0-15; op + - * = 0 1 2; paren ( ) = 0 1; end = 0
//   tok_ack             core consumes the head token when tok_valid && tok_ack
//   busy                state != IDLE
//   frame_done          one-cycle pulse after the end token is consumed
//   ovf                 sticky token-drop flag for the current frame
//   err                 sticky syntax error flag; only built when the macro
//                       AEC_ERR_CHECK_EN is defined, otherwise tied to 0
module aec_token_sequencer #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] ascii_in,
  output logic       tok_valid,
  output logic [1:0] tok_kind,
  output logic [3:0] tok_value,
  input  logic       tok_ack,
  output logic       busy,
  output logic       frame_done,
  output logic       ovf,
  output logic       err
);

  localparam logic [1:0] KIND_OPND  = 2'd0;
  localparam logic [1:0] KIND_OPER  = 2'd1;
  localparam logic [1:0] KIND_PAREN = 2'd2;
  localparam logic [1:0] KIND_END   = 2'd3;

  localparam logic [7:0] CH_EQ = 8'h3D;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Character classification (purely combinational on ascii_in)
  // ---------------------------------------------------------------------
  logic       cls_tok;
  logic [1:0] cls_kind;
  logic [3:0] cls_val;

  always_comb begin
    cls_tok  = 1'b0;
    cls_kind = KIND_OPND;
    cls_val  = 4'd0;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      // '0'-'9': the low nibble is already the value
      cls_tok = 1'b1;
      cls_val = ascii_in[3:0];
    end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
      // 'a'-'f': low nibble is 1..6, so +9 gives 10..15
      cls_tok = 1'b1;
      cls_val = ascii_in[3:0] + 4'd9;
    end else begin
      case (ascii_in)
        8'h2B: begin cls_tok = 1'b1; cls_kind = KIND_OPER;  cls_val = 4'd0; end
        8'h2D: begin cls_tok = 1'b1; cls_kind = KIND_OPER;  cls_val = 4'd1; end
        8'h2A: begin cls_tok = 1'b1; cls_kind = KIND_OPER;  cls_val = 4'd2; end
        8'h28: begin cls_tok = 1'b1; cls_kind = KIND_PAREN; cls_val = 4'd0; end
        8'h29: begin cls_tok = 1'b1; cls_kind = KIND_PAREN; cls_val = 4'd1; end
        CH_EQ: begin cls_tok = 1'b1; cls_kind = KIND_END;   cls_val = 4'd0; end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FIFO storage and control
  // ---------------------------------------------------------------------
  logic [5:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty, full;
  logic [5:0]       head;

  logic start, accept, char_tok;
  logic end_pend_q, ovf_q;
  logic pop, push_req, can_push, push, drop, synth_push;
  logic [5:0] push_dat;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = mem[rd_ptr];

  assign start    = (state_q == S_IDLE) && ready;
  assign accept   = start || (state_q == S_CAPTURE);
  assign char_tok = accept && cls_tok;

  assign pop      = !empty && tok_ack;
  // A pop in the same cycle frees the slot, so a full FIFO can still push.
  assign can_push = !full || pop;
  // Char tokens only arrive in IDLE/CAPTURE, the re-created end token only
  // in DRAIN, so the two push sources are never active together.
  assign push_req   = char_tok || ((state_q == S_DRAIN) && end_pend_q);
  assign push       = push_req && can_push;
  assign drop       = char_tok && !can_push;
  assign synth_push = (state_q == S_DRAIN) && end_pend_q && can_push;
  assign push_dat   = char_tok ? {cls_kind, cls_val} : {KIND_END, 4'd0};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  // The head entry is not reset, so mask it while empty to keep all outputs
  // at 0 after reset; it stays stable while tok_valid is high.
  assign tok_valid = !empty;
  assign tok_kind  = empty ? 2'd0 : head[5:4];
  assign tok_value = empty ? 4'd0 : head[3:0];

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // A frame consisting only of '=' skips straight to DRAIN.
        if (ready) begin
          state_d = (ascii_in == CH_EQ) ? S_DRAIN : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (ascii_in == CH_EQ) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The only end token the FIFO can hold here is this frame's own.
        if (pop && (head[5:4] == KIND_END)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Overflow flag and the pending re-created end token.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      end_pend_q <= 1'b0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (start) begin
        ovf_q <= 1'b0;
      end

      if (drop && (cls_kind == KIND_END)) begin
        end_pend_q <= 1'b1;
      end else if (start || synth_push) begin
        end_pend_q <= 1'b0;
      end
    end
  end

  assign ovf = ovf_q;

  // ---------------------------------------------------------------------
  // Optional syntax checker
  // ---------------------------------------------------------------------
`ifdef AEC_ERR_CHECK_EN
  logic [PTR_W:0] depth_q, depth_base;
  logic [1:0]     last_kind_q;
  logic           last_vld_q, last_vld_base;
  logic           cls_ws, err_hit, char_push, err_q;

  // Char tokens are the only pushes outside DRAIN.
  assign char_push = push && char_tok;

  always_comb begin
    cls_ws        = (ascii_in == 8'h20) || (ascii_in == 8'h0D) || (ascii_in == 8'h0A);
    // The first char of a frame must see a fresh context, not the last frame's.
    depth_base    = start ? '0   : depth_q;
    last_vld_base = start ? 1'b0 : last_vld_q;
    err_hit       = 1'b0;
    if (accept) begin
      if (!cls_tok && !cls_ws) begin
        err_hit = 1'b1;
      end
      if (cls_tok) begin
        if (cls_kind == KIND_PAREN && cls_val == 4'd1 && depth_base == '0) begin
          err_hit = 1'b1;
        end
        if (cls_kind == KIND_END && depth_base != '0) begin
          err_hit = 1'b1;
        end
        if (last_vld_base && cls_kind == last_kind_q &&
            (cls_kind == KIND_OPND || cls_kind == KIND_OPER)) begin
          err_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q     <= '0;
      last_kind_q <= KIND_OPND;
      last_vld_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= (err_q && !start) || err_hit;
      if (char_push) begin
        last_vld_q  <= 1'b1;
        last_kind_q <= cls_kind;
        if (cls_kind == KIND_PAREN && cls_val == 4'd0) begin
          depth_q <= depth_base + 1'b1;
        end else if (cls_kind == KIND_PAREN && depth_base != '0) begin
          depth_q <= depth_base - 1'b1;
        end else begin
          depth_q <= depth_base;
        end
      end else if (start) begin
        depth_q    <= '0;
        last_vld_q <= 1'b0;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
